// File: rtl/rsdec_pkg.sv
// Shared constants and types for the RS(n, n-4) decoder over GF(2^8), t = 2.
// The field is generated by x^8+x^7+x^2+x+1; GF_POLY holds the low byte
// (the x^8 term is implicit in the reduction step).
package rsdec_pkg;

    typedef logic [7:0] gf_t;

    localparam gf_t GF_POLY = 8'h87;
    localparam int  T       = 2;
    localparam int  NSYN    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        OMEGA = 2'd2
    } state_t;

endpackage

// File: rtl/rsdec_berl_if.sv
// Bundle between the syndrome stage, the key-equation solver and the
// Chien/Forney stages: start request, four syndromes, and the solver results.
interface rsdec_berl_if;
    import rsdec_pkg::*;

    logic start;
    gf_t  s0, s1, s2, s3;
    gf_t  lambda0, lambda1, lambda2;
    gf_t  omega0, omega1;
    logic fail;
    logic busy;
    logic done;

    modport master (
        output start, s0, s1, s2, s3,
        input  lambda0, lambda1, lambda2, omega0, omega1, fail, busy, done
    );

    modport slave (
        input  start, s0, s1, s2, s3,
        output lambda0, lambda1, lambda2, omega0, omega1, fail, busy, done
    );

endinterface

// File: rtl/rsdec_gf_mul.sv
// Combinational GF(2^8) multiplier, y = a*b reduced modulo the field polynomial.
module rsdec_gf_mul
    import rsdec_pkg::*;
(
    input  gf_t a,
    input  gf_t b,
    output gf_t y
);

    gf_t acc;

    // Horner evaluation over the bits of b: multiply the running sum by x, then add a if the bit is set
    always_comb begin
        acc = '0;
        for (int i = 7; i >= 0; i--) begin
            acc = {acc[6:0], 1'b0} ^ (acc[7] ? GF_POLY : 8'h00);
            if (b[i]) begin
                acc = acc ^ a;
            end
        end
        y = acc;
    end

endmodule

// File: rtl/rsdec_berl.sv
// Inversionless Berlekamp-Massey key-equation solver for t = 2.
// Four iterations build the (unnormalised) error locator, one more cycle
// forms the error evaluator by reusing the discrepancy multipliers.
module rsdec_berl
    import rsdec_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    rsdec_berl_if.slave bus
);

    state_t            state;
    gf_t               sr    [0:NSYN-1];
    gf_t               lam   [0:NSYN];
    gf_t               bp    [0:NSYN];
    gf_t               gamma;
    logic signed [3:0] k;
    logic [2:0]        len;
    logic [1:0]        r;

    gf_t               lambda0_q, lambda1_q, lambda2_q;
    gf_t               omega0_q, omega1_q;
    logic              fail_q, busy_q, done_q;

    gf_t               da    [0:NSYN];
    gf_t               db    [0:NSYN];
    gf_t               dy    [0:NSYN];
    gf_t               gl    [0:NSYN];
    gf_t               bsh   [0:NSYN];
    gf_t               dbx   [0:NSYN];
    gf_t               delta;

    // Discrepancy multipliers take Lambda[i]*S[r-i] while iterating; in OMEGA they form the three evaluator products
    always_comb begin
        for (int i = 0; i <= NSYN; i++) begin
            da[i] = lam[i];
            db[i] = '0;
            for (int j = 0; j < NSYN; j++) begin
                if (i + j == int'(r)) begin
                    db[i] = sr[j];
                end
            end
        end
        if (state == OMEGA) begin
            da[0] = lam[0];
            db[0] = sr[0];
            da[1] = lam[0];
            db[1] = sr[1];
            da[2] = lam[1];
            db[2] = sr[0];
            da[3] = '0;
            db[3] = '0;
            da[4] = '0;
            db[4] = '0;
        end
    end

    // Discrepancy is the field sum of the five products; x*B feeds the correction term
    always_comb begin
        delta  = '0;
        bsh[0] = '0;
        for (int i = 0; i <= NSYN; i++) begin
            delta = delta ^ dy[i];
        end
        for (int i = 1; i <= NSYN; i++) begin
            bsh[i] = bp[i-1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi <= NSYN; gi++) begin : g_mul
            rsdec_gf_mul u_delta (.a(da[gi]), .b(db[gi]),  .y(dy[gi]));
            rsdec_gf_mul u_glam  (.a(gamma),  .b(lam[gi]), .y(gl[gi]));
            rsdec_gf_mul u_dbx   (.a(delta),  .b(bsh[gi]), .y(dbx[gi]));
        end
    endgenerate

    // Control FSM with the iBM register updates and the registered result outputs
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= IDLE;
            for (int i = 0; i < NSYN; i++) begin
                sr[i] <= '0;
            end
            for (int i = 0; i <= NSYN; i++) begin
                lam[i] <= '0;
                bp[i]  <= '0;
            end
            gamma     <= '0;
            k         <= '0;
            len       <= '0;
            r         <= '0;
            lambda0_q <= '0;
            lambda1_q <= '0;
            lambda2_q <= '0;
            omega0_q  <= '0;
            omega1_q  <= '0;
            fail_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        sr[0] <= bus.s0;
                        sr[1] <= bus.s1;
                        sr[2] <= bus.s2;
                        sr[3] <= bus.s3;
                        for (int i = 0; i <= NSYN; i++) begin
                            lam[i] <= (i == 0) ? 8'h01 : 8'h00;
                            bp[i]  <= (i == 0) ? 8'h01 : 8'h00;
                        end
                        gamma  <= 8'h01;
                        k      <= '0;
                        len    <= '0;
                        r      <= '0;
                        busy_q <= 1'b1;
                        state  <= ITER;
                    end
                end
                ITER: begin
                    for (int i = 0; i <= NSYN; i++) begin
                        lam[i] <= gl[i] ^ dbx[i];
                    end
                    if ((delta != 8'h00) && !k[3]) begin
                        for (int i = 0; i <= NSYN; i++) begin
                            bp[i] <= lam[i];
                        end
                        gamma <= delta;
                        k     <= ~k;
                        len   <= {1'b0, r} + 3'd1 - len;
                    end else begin
                        for (int i = 0; i <= NSYN; i++) begin
                            bp[i] <= bsh[i];
                        end
                        k <= k + 4'sd1;
                    end
                    r <= r + 2'd1;
                    if (r == 2'd3) begin
                        state <= OMEGA;
                    end
                end
                OMEGA: begin
                    lambda0_q <= lam[0];
                    lambda1_q <= lam[1];
                    lambda2_q <= lam[2];
                    omega0_q  <= dy[0];
                    omega1_q  <= dy[1] ^ dy[2];
                    fail_q    <= (int'(len) > T);
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.lambda0 = lambda0_q;
    assign bus.lambda1 = lambda1_q;
    assign bus.lambda2 = lambda2_q;
    assign bus.omega0  = omega0_q;
    assign bus.omega1  = omega1_q;
    assign bus.fail    = fail_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_rsdec_berl.sv
// Bench for the iBM key-equation solver: fixed vectors, timing corner cases
// and random two-error patterns checked against a log/antilog-table model.
module tb_rsdec_berl;
    import rsdec_pkg::*;

    typedef gf_t syn_t  [4];
    typedef gf_t poly_t [5];

    typedef struct packed {
        logic [31:0] syn;
        gf_t         l0, l1, l2, o0, o1;
        logic        fl;
    } vec_t;

    logic clk = 1'b0;
    logic clrn;

    rsdec_berl_if bus ();

    rsdec_berl dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    gf_t         gexp [0:254];
    int          glog [0:255];
    logic [63:0] prevOut;
    vec_t        vecs [4];

    function automatic gf_t gmul(input gf_t a, input gf_t b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    function automatic logic [63:0] pack(input gf_t l0, l1, l2, o0, o1, input logic f);
        return {23'd0, l0, l1, l2, o0, o1, f};
    endfunction

    function automatic logic [63:0] outs();
        return pack(bus.lambda0, bus.lambda1, bus.lambda2, bus.omega0, bus.omega1, bus.fail);
    endfunction

    // Textbook iBM on plain arrays: returns the unnormalised locator and its length
    function automatic void refIbm(input syn_t s, output poly_t lam, output int len);
        poly_t bb;
        poly_t nl;
        gf_t   g;
        gf_t   d;
        int    kk;
        lam = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        bb  = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        g   = 8'h01;
        kk  = 0;
        len = 0;
        for (int rr = 0; rr < 4; rr++) begin
            d = 8'h00;
            for (int i = 0; i <= rr; i++) d ^= gmul(lam[i], s[rr-i]);
            for (int i = 0; i < 5; i++) nl[i] = gmul(g, lam[i]) ^ ((i > 0) ? gmul(d, bb[i-1]) : 8'h00);
            if (d != 8'h00 && kk >= 0) begin
                bb  = lam;
                g   = d;
                kk  = -kk - 1;
                len = rr + 1 - len;
            end else begin
                for (int i = 4; i > 0; i--) bb[i] = bb[i-1];
                bb[0] = 8'h00;
                kk++;
            end
            lam = nl;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] syn);
        bus.s0    = syn[31:24];
        bus.s1    = syn[23:16];
        bus.s2    = syn[15:8];
        bus.s3    = syn[7:0];
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.s0    = 8'($urandom);
        bus.s1    = 8'($urandom);
        bus.s2    = 8'($urandom);
        bus.s3    = 8'($urandom);
    endtask

    task automatic waitDone(input logic [63:0] hold, output int cyc);
        cyc = 0;
        while (cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (bus.done) break;
            checkOutput("busy while running", {63'd0, bus.busy}, 64'd1);
            checkOutput("outputs held while running", outs(), hold);
        end
    endtask

    task automatic runOne(input string name, input logic [31:0] syn, input logic [63:0] exp);
        int cyc;
        applyStimulus(syn);
        waitDone(prevOut, cyc);
        checkOutput({name, " done latency"}, 64'(cyc), 64'd5);
        checkOutput({name, " result"}, outs(), exp);
        checkOutput({name, " busy in done cycle"}, {63'd0, bus.busy}, 64'd0);
        prevOut = exp;
    endtask

    initial begin
        int          v;
        int          j1, j2;
        gf_t         e1, e2, x, ev;
        syn_t        s;
        poly_t       ml;
        int          mlen;
        logic [31:0] syn;
        logic [63:0] exp;

        gexp[0] = 8'h01;
        for (int i = 1; i < 255; i++) begin
            v       = {23'd0, gexp[i-1], 1'b0};
            if (v >= 256) v = v ^ 32'h187;
            gexp[i] = 8'(v);
        end
        for (int i = 0; i < 255; i++) glog[gexp[i]] = i;
        glog[0] = 0;

        vecs[0] = '{32'h00000000, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{32'h01010101, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 1'b0};
        vecs[2] = '{32'h02040810, 8'h08, 8'h10, 8'h00, 8'h10, 8'h00, 1'b0};
        vecs[3] = '{32'h00000001, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1};

        clrn      = 1'b0;
        bus.start = 1'b0;
        bus.s0    = 8'h00;
        bus.s1    = 8'h00;
        bus.s2    = 8'h00;
        bus.s3    = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("reset outputs", outs(), 64'd0);
        checkOutput("reset busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
        clrn = 1'b1;
        @(negedge clk);
        prevOut = 64'd0;

        for (int i = 0; i < 4; i++) begin
            runOne($sformatf("vector %0d", i), vecs[i].syn,
                   pack(vecs[i].l0, vecs[i].l1, vecs[i].l2, vecs[i].o0, vecs[i].o1, vecs[i].fl));
            @(negedge clk);
            checkOutput("done is one cycle", {63'd0, bus.done}, 64'd0);
        end

        // Start re-pulsed on edges N+2 and N+3 must not disturb the running job
        exp = pack(8'h08, 8'h10, 8'h00, 8'h10, 8'h00, 1'b0);
        applyStimulus(32'h02040810);
        @(negedge clk);
        bus.s0 = 8'h01; bus.s1 = 8'h01; bus.s2 = 8'h01; bus.s3 = 8'h01;
        bus.start = 1'b1;
        @(negedge clk);
        checkOutput("repulse no early done N+2", {63'd0, bus.done}, 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("repulse busy N+3", {63'd0, bus.busy}, 64'd1);
        @(negedge clk);
        checkOutput("repulse no early done N+4", {63'd0, bus.done}, 64'd0);
        checkOutput("repulse outputs held N+4", outs(), prevOut);
        @(negedge clk);
        checkOutput("repulse done at N+5", {63'd0, bus.done}, 64'd1);
        checkOutput("repulse result", outs(), exp);
        prevOut = exp;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("repulse single done", {62'd0, bus.busy, bus.done}, 64'd0);
        end

        // Asynchronous reset in the middle of a run clears everything at once
        applyStimulus(32'h01010101);
        repeat (2) @(negedge clk);
        clrn = 1'b0;
        #1;
        checkOutput("midrun reset outputs", outs(), 64'd0);
        checkOutput("midrun reset busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
        @(negedge clk);
        clrn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("no done after reset", {62'd0, bus.busy, bus.done}, 64'd0);
        end
        prevOut = 64'd0;
        runOne("after reset", 32'h01010101, pack(8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 1'b0));

        // Random two-error patterns, issued back to back so each start lands in the previous done cycle
        for (int n = 0; n < 500; n++) begin
            j1 = $urandom_range(0, 254);
            do j2 = $urandom_range(0, 254); while (j2 == j1);
            e1 = 8'($urandom_range(1, 255));
            e2 = 8'($urandom_range(1, 255));
            for (int i = 0; i < 4; i++) begin
                s[i] = gmul(e1, gexp[((i + 1) * j1) % 255]) ^ gmul(e2, gexp[((i + 1) * j2) % 255]);
            end
            syn = {s[0], s[1], s[2], s[3]};
            refIbm(s, ml, mlen);
            exp = pack(ml[0], ml[1], ml[2], gmul(s[0], ml[0]),
                       gmul(s[1], ml[0]) ^ gmul(s[0], ml[1]), 1'b0);
            runOne("random", syn, exp);
            checkOutput("random model length", 64'(mlen), 64'd2);
            x  = gexp[(255 - j1) % 255];
            ev = bus.lambda0 ^ gmul(bus.lambda1, x) ^ gmul(bus.lambda2, gmul(x, x));
            checkOutput("random root j1", {56'd0, ev}, 64'd0);
            x  = gexp[(255 - j2) % 255];
            ev = bus.lambda0 ^ gmul(bus.lambda1, x) ^ gmul(bus.lambda2, gmul(x, x));
            checkOutput("random root j2", {56'd0, ev}, 64'd0);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
